// File: rtl/multiplicar.sv
// Sequential shift-add multiplier for unsigned Q8.12 operands, one multiplier bit per clock.
// Optional round-to-nearest on the result when MULTIPLICAR_ARRED_EN is defined.
module multiplicar (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inicio,
    input  logic [19:0] multiplicando,
    input  logic [19:0] multiplicador,
    output logic [19:0] produto,
    output logic        pronto,
    output logic        ocupado,
    output logic        overflow
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    estado_t     estado_r, estadoProx_s;
    logic [19:0] operA_r, operAProx_s;
    logic [19:0] operB_r, operBProx_s;
    logic [39:0] acum_r, acumProx_s, parcela_s;
    logic [4:0]  contador_r, contadorProx_s;
    logic [19:0] produto_r, produtoProx_s;
    logic        overflow_r, overflowProx_s;
    logic        pronto_r, prontoProx_s;
    logic        ocupado_r, ocupadoProx_s;
    logic [20:0] final_s;

    // Packs {overflow, produto} from the full 40-bit Q16.24 accumulator.
    function automatic logic [20:0] finaliza(input logic [39:0] acc);
`ifdef MULTIPLICAR_ARRED_EN
        logic [20:0] soma;
        soma = {1'b0, acc[31:12]} + {20'd0, acc[11]};
        return {(|acc[39:32]) | soma[20], soma[19:0]};
`else
        return {|acc[39:32], acc[31:12]};
`endif
    endfunction

    // Next-state, datapath and output-register values.
    always_comb begin
        estadoProx_s   = estado_r;
        operAProx_s    = operA_r;
        operBProx_s    = operB_r;
        acumProx_s     = acum_r;
        contadorProx_s = contador_r;
        produtoProx_s  = produto_r;
        overflowProx_s = overflow_r;
        prontoProx_s   = 1'b0;
        ocupadoProx_s  = 1'b0;
        if (operB_r[contador_r]) begin
            parcela_s = acum_r + ({20'd0, operA_r} << contador_r);
        end else begin
            parcela_s = acum_r;
        end
        final_s = finaliza(parcela_s);
        case (estado_r)
            OCIOSO: begin
                if (inicio) begin
                    operAProx_s    = multiplicando;
                    operBProx_s    = multiplicador;
                    acumProx_s     = 40'd0;
                    contadorProx_s = 5'd0;
                    ocupadoProx_s  = 1'b1;
                    estadoProx_s   = CALCULA;
                end else begin
                    estadoProx_s   = OCIOSO;
                end
            end
            CALCULA: begin
                acumProx_s     = parcela_s;
                contadorProx_s = contador_r + 5'd1;
                // Last bit: the result registers load together with the FIM transition.
                if (contador_r == 5'd19) begin
                    produtoProx_s  = final_s[19:0];
                    overflowProx_s = final_s[20];
                    prontoProx_s   = 1'b1;
                    ocupadoProx_s  = 1'b0;
                    estadoProx_s   = FIM;
                end else begin
                    ocupadoProx_s  = 1'b1;
                    estadoProx_s   = CALCULA;
                end
            end
            FIM: begin
                estadoProx_s = OCIOSO;
            end
            default: begin
                estadoProx_s = OCIOSO;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r   <= OCIOSO;
            operA_r    <= 20'd0;
            operB_r    <= 20'd0;
            acum_r     <= 40'd0;
            contador_r <= 5'd0;
            produto_r  <= 20'd0;
            overflow_r <= 1'b0;
            pronto_r   <= 1'b0;
            ocupado_r  <= 1'b0;
        end else begin
            estado_r   <= estadoProx_s;
            operA_r    <= operAProx_s;
            operB_r    <= operBProx_s;
            acum_r     <= acumProx_s;
            contador_r <= contadorProx_s;
            produto_r  <= produtoProx_s;
            overflow_r <= overflowProx_s;
            pronto_r   <= prontoProx_s;
            ocupado_r  <= ocupadoProx_s;
        end
    end

    assign produto  = produto_r;
    assign overflow = overflow_r;
    assign pronto   = pronto_r;
    assign ocupado  = ocupado_r;

endmodule

// File: tb/tb_multiplicar.sv
// Self-checking bench for multiplicar: directed scenarios plus randomized operands
// compared against an arithmetic reference model.
module tb_multiplicar;

    logic        clk;
    logic        rst_n;
    logic        inicio;
    logic [19:0] multiplicando;
    logic [19:0] multiplicador;
    logic [19:0] produto;
    logic        pronto;
    logic        ocupado;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    multiplicar dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inicio       (inicio),
        .multiplicando(multiplicando),
        .multiplicador(multiplicador),
        .produto      (produto),
        .pronto       (pronto),
        .ocupado      (ocupado),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact product, then Q8.12 extraction; overflow when the value exceeds 20 bits.
    function automatic logic [20:0] modelo(input logic [19:0] a, input logic [19:0] b);
        logic [63:0] p;
        logic [63:0] q;
        p = {44'd0, a} * {44'd0, b};
`ifdef MULTIPLICAR_ARRED_EN
        q = (p >> 12) + ((p >> 11) & 64'd1);
`else
        q = p >> 12;
`endif
        return {(q > 64'hFFFFF), q[19:0]};
    endfunction

    // Drive a one-cycle start; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [19:0] a, input logic [19:0] b);
        multiplicando = a;
        multiplicador = b;
        inicio = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inicio = 1'b0;
    endtask

    // Counts edges (accepting edge = 1) until pronto is seen; -1 on timeout.
    task automatic wait_pronto(input int start, output int edges);
        bit seen;
        seen = 1'b0;
        edges = start;
        while (!seen && edges < 80) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (pronto) seen = 1'b1;
        end
        if (!seen) edges = -1;
    endtask

    task automatic test_reset();
        int e;
        logic [20:0] exp;
        rst_n = 1'b0;
        inicio = 1'b1;
        multiplicando = 20'h01800;
        multiplicador = 20'h02000;
        #1;
        checks++; if (produto !== 20'd0 || overflow !== 1'b0 || pronto !== 1'b0 || ocupado !== 1'b0) begin
            failures++; $display("FAIL reset_t0: produto=%h ovf=%b pronto=%b ocupado=%b, want all 0", produto, overflow, pronto, ocupado);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ocupado !== 1'b0 || pronto !== 1'b0) begin
            failures++; $display("FAIL reset_hold: ocupado=%b pronto=%b, want 0 0", ocupado, pronto);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inicio = 1'b0;
        checks++; if (ocupado !== 1'b1) begin
            failures++; $display("FAIL reset_first_start: ocupado=%b, want 1", ocupado);
        end
        wait_pronto(1, e);
        exp = modelo(20'h01800, 20'h02000);
        checks++; if (e !== 21 || produto !== exp[19:0]) begin
            failures++; $display("FAIL reset_first_op: edges=%0d produto=%h, want 21 %h", e, produto, exp[19:0]);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        int e;
        start_op(20'h01800, 20'h02000);
        checks++; if (ocupado !== 1'b1) begin
            failures++; $display("FAIL basic_busy: ocupado=%b, want 1", ocupado);
        end
        wait_pronto(1, e);
        checks++; if (e !== 21) begin
            failures++; $display("FAIL basic_latency: edges=%0d, want 21", e);
        end
        checks++; if (produto !== 20'h03000 || overflow !== 1'b0 || ocupado !== 1'b0) begin
            failures++; $display("FAIL basic_result: produto=%h ovf=%b ocupado=%b, want 03000 0 0", produto, overflow, ocupado);
        end
        @(negedge clk);
        checks++; if (pronto !== 1'b0) begin
            failures++; $display("FAIL basic_pulse: pronto=%b, want 0", pronto);
        end
        repeat (4) @(negedge clk);
        checks++; if (produto !== 20'h03000) begin
            failures++; $display("FAIL basic_hold: produto=%h, want 03000", produto);
        end
    endtask

    task automatic test_overflow();
        int e;
        start_op(20'h80000, 20'h02000);
        wait_pronto(1, e);
        checks++; if (e !== 21 || produto !== 20'h00000 || overflow !== 1'b1) begin
            failures++; $display("FAIL overflow: edges=%0d produto=%h ovf=%b, want 21 00000 1", e, produto, overflow);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rounding();
        int e;
        logic [19:0] want;
`ifdef MULTIPLICAR_ARRED_EN
        want = 20'h00001;
`else
        want = 20'h00000;
`endif
        start_op(20'h00001, 20'h00800);
        wait_pronto(1, e);
        checks++; if (produto !== want || overflow !== 1'b0) begin
            failures++; $display("FAIL rounding: produto=%h ovf=%b, want %h 0", produto, overflow, want);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy();
        int e;
        int extra;
        logic [20:0] exp;
        exp = modelo(20'h03400, 20'h05800);
        start_op(20'h03400, 20'h05800);
        repeat (4) @(negedge clk);
        multiplicando = 20'hFFFFF;
        multiplicador = 20'h12345;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        multiplicando = 20'h00777;
        wait_pronto(6, e);
        checks++; if (e !== 21 || produto !== exp[19:0] || overflow !== exp[20]) begin
            failures++; $display("FAIL busy_result: edges=%0d produto=%h ovf=%b, want 21 %h %b", e, produto, overflow, exp[19:0], exp[20]);
        end
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (pronto) extra++;
        end
        checks++; if (extra !== 0) begin
            failures++; $display("FAIL busy_single_pulse: extra pulses=%0d, want 0", extra);
        end
    endtask

    task automatic test_reset_midop();
        int e;
        int spurious;
        start_op(20'h02000, 20'h02000);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (produto !== 20'd0 || overflow !== 1'b0 || pronto !== 1'b0 || ocupado !== 1'b0) begin
            failures++; $display("FAIL midop_async_clear: produto=%h ovf=%b pronto=%b ocupado=%b, want all 0", produto, overflow, pronto, ocupado);
        end
        spurious = 0;
        repeat (3) begin
            @(negedge clk);
            if (pronto || ocupado) spurious++;
        end
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (pronto || ocupado) spurious++;
        end
        checks++; if (spurious !== 0) begin
            failures++; $display("FAIL midop_no_pronto: activity cycles=%0d, want 0", spurious);
        end
        start_op(20'h01000, 20'h0FFFF);
        wait_pronto(1, e);
        checks++; if (e !== 21 || produto !== 20'h0FFFF || overflow !== 1'b0) begin
            failures++; $display("FAIL midop_fresh: edges=%0d produto=%h ovf=%b, want 21 0ffff 0", e, produto, overflow);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int e;
        logic [19:0] a;
        logic [19:0] b;
        logic [20:0] exp;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                a = 20'($urandom_range(0, 32'h0FFFF));
                b = 20'($urandom_range(0, 32'h0FFFF));
            end else begin
                a = 20'($urandom_range(0, 32'hFFFFF));
                b = 20'($urandom_range(0, 32'hFFFFF));
            end
            exp = modelo(a, b);
            start_op(a, b);
            wait_pronto(1, e);
            checks++; if (e !== 21 || produto !== exp[19:0] || overflow !== exp[20]) begin
                failures++; $display("FAIL random_%0d: a=%h b=%h edges=%0d produto=%h ovf=%b, want 21 %h %b", i, a, b, e, produto, overflow, exp[19:0], exp[20]);
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int edge_n;
        int n;
        int pulses[3];
        n = 0;
        edge_n = 0;
        multiplicando = 20'h00000;
        multiplicador = 20'hFFFFF;
        inicio = 1'b1;
        while (n < 3 && edge_n < 120) begin
            @(posedge clk);
            edge_n++;
            @(negedge clk);
            if (pronto) begin
                pulses[n] = edge_n;
                n++;
                checks++; if (produto !== 20'd0 || overflow !== 1'b0) begin
                    failures++; $display("FAIL b2b_result_%0d: produto=%h ovf=%b, want 00000 0", n, produto, overflow);
                end
            end
        end
        inicio = 1'b0;
        checks++; if (n !== 3) begin
            failures++; $display("FAIL b2b_count: pulses=%0d, want 3", n);
        end else begin
            checks++; if (pulses[0] !== 21 || pulses[1] - pulses[0] !== 22 || pulses[2] - pulses[1] !== 22) begin
                failures++; $display("FAIL b2b_period: pulses at %0d %0d %0d, want 21 43 65", pulses[0], pulses[1], pulses[2]);
            end
        end
        repeat (25) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_rounding();
        test_busy();
        test_reset_midop();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
